fir_mac_sequencer: RTL and testbench

- Sequenced FIR filter. Shares one signed multiplier and accumulator across all taps.
- Accepts one sample per valid/ready handshake and shifts it into an internal TAPS-deep delay line.
- Walks the taps one per cycle, then presents the full-precision sum on a valid/ready output.
- Coefficients are run-time configurable through a register write port. The block is the control and scheduling layer for the sample delay line.

---
 rtl/fir_mac_sequencer.sv | 101 ++++++++++
 tb/tb_fir_mac_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Sequenced FIR filter: one shared signed multiplier and accumulator walk all
// taps one per cycle, then the full-precision sum is held on a valid/ready port.
module fir_mac_sequencer #(
    parameter int BITS = 8,
    parameter int TAPS = 4,
    localparam int ACC_BITS = 2*BITS + $clog2(TAPS),
    localparam int IW = $clog2(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BITS-1:0]     in_data,
    input  logic                       coef_we,
    input  logic [IW-1:0]              coef_addr,
    input  logic signed [BITS-1:0]     coef_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_BITS-1:0] out_data,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state_q, state_d;

    logic [TAPS-1:0][BITS-1:0]  smp_q, smp_d;
    logic [TAPS-1:0][BITS-1:0]  coef_q, coef_d;
    logic signed [ACC_BITS-1:0] acc_q, acc_d;
    logic [IW-1:0]              idx_q, idx_d;

    logic                       accept;
    logic                       last_tap;
    logic                       coef_hit;
    logic signed [2*BITS-1:0]   prod;

    assign accept   = in_valid && in_ready;
    assign last_tap = (idx_q == IW'(TAPS-1));
    // Guards non-power-of-two TAPS where the address can exceed the table.
    assign coef_hit = coef_we && ({1'b0, coef_addr} < (IW+1)'(TAPS));
    assign prod     = $signed(smp_q[idx_q]) * $signed(coef_q[idx_q]);

    // State register; reset abandons any computation in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: accept -> TAPS MAC cycles -> hold result until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (last_tap) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; in_ready is masked by reset directly.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
        out_data  = acc_q;
    end

    // Datapath next-state: delay-line shift, MAC step, coefficient writes.
    always_comb begin
        smp_d  = smp_q;
        coef_d = coef_q;
        acc_d  = acc_q;
        idx_d  = idx_q;
        if (accept) begin
            smp_d = {smp_q[TAPS-2:0], in_data};
            acc_d = '0;
            idx_d = '0;
        end else if (state_q == MAC) begin
            acc_d = acc_q + {{(ACC_BITS-2*BITS){prod[2*BITS-1]}}, prod};
            idx_d = idx_q + 1'b1;
        end
        // The MAC read above uses coef_q, so a same-cycle write lands next read.
        if (coef_hit) coef_d[coef_addr] = coef_data;
    end

    // Datapath registers; reset clears history, coefficients and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q  <= '0;
            coef_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
        end else begin
            smp_q  <= smp_d;
            coef_q <= coef_d;
            acc_q  <= acc_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: expected sums are queued when samples
// are driven and compared when the output handshake completes.
module tb_fir_mac_sequencer;

    localparam int BITS = 8;
    localparam int TAPS = 4;
    localparam int ACC_BITS = 2*BITS + $clog2(TAPS);

    logic                       clk = 0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [BITS-1:0]     in_data;
    logic                       coef_we;
    logic [1:0]                 coef_addr;
    logic signed [BITS-1:0]     coef_data;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [ACC_BITS-1:0] out_data;
    logic                       busy;

    fir_mac_sequencer #(.BITS(BITS), .TAPS(TAPS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic signed [ACC_BITS-1:0] exp_q[$];
    int                         lat_q[$];
    int                         m_smp [TAPS];
    int                         m_coef[TAPS];
    bit                         chk_period = 0;
    int                         last_acc = -1;
    logic                       ov_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: accept timing, latency, and scoreboard compare on output handshake.
    always @(negedge clk) begin
        if (in_valid && in_ready) begin
            lat_q.push_back(cyc + 1);
            if (chk_period && last_acc >= 0) begin
                total++;
                if (cyc + 1 - last_acc != TAPS + 2)
                    $display("FAIL accept_period: got %0d want %0d", cyc + 1 - last_acc, TAPS + 2);
                else passed++;
            end
            last_acc = cyc + 1;
        end
        if (out_valid && !ov_prev && lat_q.size() > 0) begin
            int t;
            t = lat_q.pop_front();
            total++;
            if (cyc != t + TAPS)
                $display("FAIL latency: out_valid after edge %0d want %0d", cyc, t + TAPS);
            else passed++;
        end
        ov_prev = out_valid;
        if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output: got %0d with empty scoreboard", out_data);
            end else begin
                logic signed [ACC_BITS-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) $display("FAIL out_data: got %0d want %0d", out_data, e);
                else passed++;
            end
        end
    end

    function automatic logic signed [ACC_BITS-1:0] calc();
        int s = 0;
        for (int k = 0; k < TAPS; k++) s += m_smp[k] * m_coef[k];
        return ACC_BITS'(s);
    endfunction

    task automatic shift_model(input logic signed [BITS-1:0] d);
        for (int k = TAPS-1; k > 0; k--) m_smp[k] = m_smp[k-1];
        m_smp[0] = int'(d);
    endtask

    task automatic write_coef(input int a, input logic signed [BITS-1:0] v);
        coef_we = 1; coef_addr = 2'(a); coef_data = v;
        @(posedge clk); #1;
        coef_we = 0;
        m_coef[a] = int'(v);
    endtask

    // Drive one sample and wait for its handshake; mode 0: model, 1: explicit e, 2: no result expected.
    task automatic send(input logic signed [BITS-1:0] d, input int mode,
                        input logic signed [ACC_BITS-1:0] e);
        bit ok = 0;
        shift_model(d);
        if (mode == 0) exp_q.push_back(calc());
        else if (mode == 1) exp_q.push_back(e);
        in_valid = 1; in_data = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        total++;
        if (!ok) $display("FAIL accept_timeout: in_ready stayed %b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        total++;
        if (!ok) $display("FAIL drain_timeout: %0d results outstanding want 0", exp_q.size());
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; in_data = 0; out_ready = 1;
        coef_we = 0; coef_addr = 0; coef_data = 0;
        for (int k = 0; k < TAPS; k++) begin m_smp[k] = 0; m_coef[k] = 0; end
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== '0)
            $display("FAIL reset_outputs: rdy/vld/busy=%b data=%0d want 000 0",
                     {in_ready, out_valid, busy}, out_data);
        else passed++;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_impulse();
        for (int k = 0; k < TAPS; k++) write_coef(k, BITS'(k + 1));
        send(8'sd1, 1, 18'sd1);
        send(8'sd0, 1, 18'sd2);
        send(8'sd0, 1, 18'sd3);
        send(8'sd0, 1, 18'sd4);
        send(8'sd0, 1, 18'sd0);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < TAPS; k++) write_coef(k, 8'sd1);
        last_acc = -1; chk_period = 1;
        send(8'sd5, 1, 18'sd5);
        send(8'sd5, 1, 18'sd10);
        send(8'sd5, 1, 18'sd15);
        drain();
        chk_period = 0;
    endtask

    task automatic test_backpressure();
        bit ok = 0;
        bit stable = 1;
        out_ready = 0;
        send(8'sd2, 1, 18'sd17);       // history 2,5,5,5 with unit coefs
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        total++;
        if (!ok) $display("FAIL bp_valid_timeout: out_valid=%b want 1", out_valid);
        else passed++;
        @(posedge clk); #1;
        shift_model(8'sd3);
        exp_q.push_back(18'sd15);      // history 3,2,5,5
        in_valid = 1; in_data = 8'sd3;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 18'sd17 || in_ready !== 1'b0) stable = 0;
        end
        total++;
        if (!stable) $display("FAIL bp_hold: vld=%b data=%0d rdy=%b want 1 17 0",
                              out_valid, out_data, in_ready);
        else passed++;
        @(posedge clk); #1;
        out_ready = 1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) $display("FAIL bp_no_accept_in_out: in_ready=%b want 0", in_ready);
        else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL bp_accept_after_out: rdy/busy=%b%b want 10", in_ready, busy);
        else passed++;
        @(posedge clk); #1;
        in_valid = 0;
        drain();
    endtask

    task automatic test_mid_mac_coef();
        for (int k = 0; k < TAPS; k++) write_coef(k, BITS'(k + 1));
        // History becomes 1,3,2,5: old coef[1]=2, new coef[3]=7 -> 1+6+6+35.
        send(8'sd1, 1, 18'sd48);
        @(posedge clk); #1;            // MAC cycle reading tap 1
        write_coef(1, 8'sd9);
        write_coef(3, 8'sd7);
        send(8'sd0, 1, 18'sd32);       // history 0,1,3,2 with 1,9,3,7
        drain();
    endtask

    task automatic test_signed();
        for (int k = 0; k < TAPS; k++) write_coef(k, -8'sd128);
        for (int n = 0; n < TAPS - 1; n++) send(-8'sd128, 0, '0);
        send(-8'sd128, 1, 18'sd65536);
        for (int k = 0; k < TAPS; k++) write_coef(k, 8'sd127);
        send(-8'sd128, 1, -18'sd65024);
        drain();
    endtask

    task automatic test_reset_mid_mac();
        bit saw = 0;
        write_coef(0, 8'sd3);
        send(8'sd4, 2, '0);
        rst = 1; coef_we = 1; coef_addr = 0; coef_data = 8'sd5;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) $display("FAIL rst_ready_low: got %b want 0", in_ready);
        else passed++;
        @(posedge clk); #1;
        rst = 0; coef_we = 0;
        lat_q.delete();
        for (int k = 0; k < TAPS; k++) begin m_smp[k] = 0; m_coef[k] = 0; end
        @(negedge clk);
        total++;
        if ({in_ready, busy, out_valid} !== 3'b100)
            $display("FAIL rst_mid_mac_state: rdy/busy/vld=%b want 100", {in_ready, busy, out_valid});
        else passed++;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        total++;
        if (saw) $display("FAIL rst_no_output: out_valid seen 1 want 0");
        else passed++;
        @(posedge clk); #1;
        send(8'sd5, 1, 18'sd0);
        send(8'sd7, 1, 18'sd0);
        drain();
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_back_to_back();
        test_backpressure();
        test_mid_mac_coef();
        test_signed();
        test_reset_mid_mac();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
